// File: rtl/xbee_pkg.sv
// Shared constants, event encoding and message byte table for the XBee status-message scheduler.
package xbee_pkg;

  typedef logic [3:0] evt_t;  // {type, colour}

  localparam logic EvtNode   = 1'b0;
  localparam logic EvtSupply = 1'b1;

  localparam logic [2:0] ColorFire     = 3'd1;
  localparam logic [2:0] ColorCritical = 3'd2;

  localparam logic [3:0] NodeMsgLen   = 4'd7;
  localparam logic [3:0] SupMsgLen    = 4'd9;
  localparam logic [3:0] NodeCountMax = 4'd9;

  localparam logic [7:0] AsciiHash = 8'h23;
  localparam logic [7:0] AsciiDash = 8'h2D;
  localparam logic [7:0] Ascii0    = 8'h30;
  localparam logic [7:0] AsciiC    = 8'h43;
  localparam logic [7:0] AsciiD    = 8'h44;
  localparam logic [7:0] AsciiE    = 8'h45;
  localparam logic [7:0] AsciiF    = 8'h46;
  localparam logic [7:0] AsciiI    = 8'h49;
  localparam logic [7:0] AsciiN    = 8'h4E;
  localparam logic [7:0] AsciiO    = 8'h4F;
  localparam logic [7:0] AsciiS    = 8'h53;
  localparam logic [7:0] AsciiT    = 8'h54;
  localparam logic [7:0] AsciiW    = 8'h57;

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StWaitAck, StWaitDone} state_e;

  function automatic logic [7:0] msg_byte(input evt_t entry, input logic [3:0] idx,
                                          input logic [3:0] count);
    logic [7:0] b;
    logic [7:0] c1;
    logic [7:0] c2;
    b = 8'h00;
    case (entry[2:0])
      ColorFire:     begin c1 = AsciiF; c2 = AsciiI; end
      ColorCritical: begin c1 = AsciiC; c2 = AsciiT; end
      default:       begin c1 = AsciiC; c2 = AsciiS; end
    endcase
    case ({entry[3], idx})
      5'h00: b = AsciiN;
      5'h01: b = AsciiO;
      5'h02: b = AsciiD;
      5'h03: b = AsciiE;
      5'h04: b = Ascii0 + {4'd0, count};
      5'h05: b = AsciiDash;
      5'h06: b = AsciiHash;
      5'h10: b = AsciiS;
      5'h11: b = AsciiI;
      5'h12: b = AsciiDash;
      5'h13: b = AsciiW;
      5'h14: b = AsciiDash;
      5'h15: b = c1;
      5'h16: b = c2;
      5'h17: b = AsciiDash;
      5'h18: b = AsciiHash;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/xbee_evt_fifo.sv
// Event queue with two write ports (node slot first) and one read port; caller qualifies writes.
module xbee_evt_fifo
  import xbee_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic wr0_en_i,
  input  evt_t wr0_data_i,
  input  logic wr1_en_i,
  input  evt_t wr1_data_i,
  input  logic rd_en_i,
  output evt_t rd_data_o,
  output logic full_o,
  output logic one_free_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  evt_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wr1_ptr, used;

  // Second write lands behind the first when both are accepted.
  assign wr1_ptr = wptr_q + PW'(wr0_en_i);
  assign used    = wptr_q - rptr_q;
  assign wptr_d  = wptr_q + PW'(wr0_en_i) + PW'(wr1_en_i);
  assign rptr_d  = rptr_q + PW'(rd_en_i);

  assign empty_o    = (wptr_q == rptr_q);
  assign full_o     = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
  assign one_free_o = (used == PW'(FIFO_DEPTH - 1));
  assign rd_data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge CLOCK) begin
    if (wr0_en_i) mem_q[wptr_q[AW-1:0]] <= wr0_data_i;
    if (wr1_en_i) mem_q[wr1_ptr[AW-1:0]] <= wr1_data_i;
  end

  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/xbee_msg_scheduler.sv
// Queues node/supply events and streams their ASCII messages to the UART transmitter byte by byte.
module xbee_msg_scheduler
  import xbee_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       node_req_i,
  input  logic       sup_req_i,
  input  logic [2:0] sup_color_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_byte_o,
  output logic [3:0] node_count_o,
  output logic       evt_overflow_o,
  output logic       sched_idle_o
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;

  state_e        state_q, state_d;
  evt_t          entry_q, entry_d, fifo_rdata;
  logic [3:0]    idx_q, idx_d, node_count_q, node_count_d, last_idx;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          busy_q, ovf_q;
  logic          pop, fifo_full, fifo_one_free, fifo_empty;
  logic          room_one, room_two, wr0_ok, wr1_ok, drop;

  // A pop in the same cycle frees a slot before the writes are judged.
  assign room_one = !fifo_full || pop;
  assign room_two = !fifo_full && (pop || !fifo_one_free);
  assign wr0_ok   = node_req_i && room_one;
  assign wr1_ok   = sup_req_i && (node_req_i ? room_two : room_one);
  assign drop     = (node_req_i && !wr0_ok) || (sup_req_i && !wr1_ok);

  xbee_evt_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLOCK      (CLOCK),
    .rst        (rst),
    .wr0_en_i   (wr0_ok),
    .wr0_data_i ({EvtNode, 3'b000}),
    .wr1_en_i   (wr1_ok),
    .wr1_data_i ({EvtSupply, sup_color_i}),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_rdata),
    .full_o     (fifo_full),
    .one_free_o (fifo_one_free),
    .empty_o    (fifo_empty)
  );

  assign last_idx = (entry_q[3] == EvtSupply) ? SupMsgLen - 4'd1 : NodeMsgLen - 4'd1;

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    idx_d        = idx_q;
    tx_byte_d    = tx_byte_q;
    node_count_d = node_count_q;
    to_cnt_d     = to_cnt_q;
    pop          = 1'b0;
    case (state_q)
      StIdle: if (!fifo_empty) state_d = StLoad;
      StLoad: begin
        pop       = 1'b1;
        entry_d   = fifo_rdata;
        idx_d     = 4'd0;
        tx_byte_d = msg_byte(fifo_rdata, 4'd0, node_count_q);
        if (fifo_rdata[3] == EvtNode && node_count_q != NodeCountMax) begin
          node_count_d = node_count_q + 4'd1;
        end
        state_d   = StSend;
      end
      StSend: begin
        to_cnt_d = '0;
        state_d  = StWaitAck;
      end
      StWaitAck: begin
        if (busy_q) begin
          state_d = StWaitDone;
        end else if (to_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = StSend;  // byte and index untouched: re-issue
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      StWaitDone: begin
        if (!busy_q) begin
          if (idx_q == last_idx) begin
            state_d = StIdle;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_byte_d = msg_byte(entry_q, idx_q + 4'd1, node_count_q);
            state_d   = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      state_q      <= StIdle;
      entry_q      <= '0;
      idx_q        <= '0;
      tx_byte_q    <= 8'h00;
      node_count_q <= '0;
      to_cnt_q     <= '0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      idx_q        <= idx_d;
      tx_byte_q    <= tx_byte_d;
      node_count_q <= node_count_d;
      to_cnt_q     <= to_cnt_d;
      busy_q       <= tx_busy_i;
      ovf_q        <= ovf_q | drop;
    end
  end

  assign tx_start_o     = (state_q == StSend);
  assign tx_byte_o      = tx_byte_q;
  assign node_count_o   = node_count_q;
  assign evt_overflow_o = ovf_q;
  assign sched_idle_o   = (state_q == StIdle) && fifo_empty;

endmodule
